// File: rtl/jk_sync_counter4.sv
// Synchronous up-counter built from JK master-slave stages with look-ahead toggle enables.
// The count advances on the falling clock edge; clear is asynchronous and active-low.
module jk_sync_counter4 #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             count_enable,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qbar
);

   logic [WIDTH-1:0] r_slave;
   logic [WIDTH-1:0] w_toggle;
   logic [WIDTH-1:0] w_jkJ;
   logic [WIDTH-1:0] w_jkK;
   logic [WIDTH-1:0] w_master;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_stage
         // Each stage's toggle is a direct AND of all lower bits, so the carry never ripples.
         if (i == 0) begin : g_lsb
            assign w_toggle[i] = count_enable;
         end else begin : g_upper
            assign w_toggle[i] = count_enable & (&r_slave[i-1:0]);
         end

         assign w_jkJ[i]    = w_toggle[i];
         assign w_jkK[i]    = w_toggle[i];
         assign w_master[i] = (w_jkJ[i] & ~r_slave[i]) | (~w_jkK[i] & r_slave[i]);
      end
   endgenerate

   // Master value is transparent while clock is high; the slave takes it on the falling edge.
   always_ff @(negedge clock or negedge clear) begin
      if (!clear) begin
         r_slave <= '0;
      end else begin
         r_slave <= w_master;
      end
   end

   assign Q    = r_slave;
   assign Qbar = ~r_slave;

endmodule

// File: tb/tb_jk_sync_counter4.sv
// Self-checking bench for jk_sync_counter4: directed test plan steps followed by random enable/clear traffic.
module tb_jk_sync_counter4;

   localparam int WIDTH = 4;
   localparam int MODULUS = 16;

   logic             clock;
   logic             clear;
   logic             count_enable;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] Qbar;

   int total;
   int bad;
   int modelCount;

   jk_sync_counter4 #(.WIDTH(WIDTH)) dut (
      .clock        (clock),
      .clear        (clear),
      .count_enable (count_enable),
      .Q            (Q),
      .Qbar         (Qbar)
   );

   // Free-running clock, period 10, low for the first half period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Watchdog bounds the whole run.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag);
      logic [WIDTH-1:0] expQ;
      expQ = WIDTH'(modelCount);
      total++;
      assert (Q === expQ && Qbar === ~expQ)
      else begin
         bad++;
         $error("[TB] FAIL %s: Q=%b Qbar=%b expected Q=%b Qbar=%b", tag, Q, Qbar, expQ, ~expQ);
      end
   endtask

   // The model counts an event whenever clear is high and enable is high at a falling edge.
   task automatic fallCheck(input string tag);
      @(negedge clock);
      if (clear === 1'b1 && count_enable === 1'b1)
         modelCount = (modelCount + 1) % MODULUS;
      #1;
      checkOutput(tag);
   endtask

   task automatic riseCheck(input string tag);
      @(posedge clock);
      #1;
      checkOutput(tag);
   endtask

   task automatic applyStimulus(input string tag, input int cycles);
      for (int n = 0; n < cycles; n++) begin
         riseCheck({tag, "_rise"});
         fallCheck(tag);
      end
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      modelCount   = 0;
      clear        = 1'b0;
      count_enable = 1'b1;

      // Reset is visible with no clock edge at all.
      #1;
      checkOutput("resetNoEdge");
      #2;
      checkOutput("resetHeld");

      // Release during the low phase with enable off: nothing counts.
      #1;
      clear        = 1'b1;
      count_enable = 1'b0;
      #1;
      checkOutput("release");
      applyStimulus("holdAfterRelease", 2);

      // Full wrap from 0 through 15 back to 0.
      count_enable = 1'b1;
      applyStimulus("countWrap", 16);
      total++;
      assert (Q === 4'b0000)
      else begin
         bad++;
         $error("[TB] FAIL wrapZero: Q=%b expected Q=0000", Q);
      end

      // Count to 5, then clear in the middle of a high phase for 20 time units.
      applyStimulus("countTo5", 5);
      @(posedge clock);
      #2;
      clear      = 1'b0;
      modelCount = 0;
      #1;
      checkOutput("asyncClrInstant");
      #9;
      checkOutput("asyncClrEdge1");
      #8;
      checkOutput("asyncClrEdge2");
      #2;
      clear = 1'b1;
      fallCheck("afterAsyncClr");

      // Count to 3, drop enable for three edges, re-enable.
      applyStimulus("countTo3", 2);
      count_enable = 1'b0;
      applyStimulus("enableDrop", 3);
      count_enable = 1'b1;
      applyStimulus("reEnable", 1);

      // Carry chain 0111 -> 1000 and 1111 -> 0000.
      applyStimulus("countTo7", 3);
      fallCheck("carry7to8");
      applyStimulus("countTo15", 7);
      fallCheck("carry15to0");

      // Clear asserted exactly at a falling edge wins over the count.
      applyStimulus("preEdgeClr", 3);
      @(negedge clock);
      clear      = 1'b0;
      modelCount = 0;
      #1;
      checkOutput("clrAtEdge");
      #1;
      clear = 1'b1;
      fallCheck("afterEdgeClr");

      // Random enable pattern with occasional mid-high-phase clear pulses.
      for (int n = 0; n < 300; n++) begin
         count_enable = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 19) == 0) begin
            @(posedge clock);
            #1;
            clear      = 1'b0;
            modelCount = 0;
            #1;
            checkOutput("randClr");
            #1;
            clear = 1'b1;
            fallCheck("randAfterClr");
         end else begin
            applyStimulus("rand", 1);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
